gray_input_conditioner: RTL and testbench
=========================================

GRAY_INPUT_CONDITIONER -- requirements
Module: gray_input_conditioner

Interface
- REQ-001: Parameter STABLE_CYCLES, default 4, SHALL set the consecutive synchronized cycles an input must hold before commit; legal range 1..255.
- REQ-002: clk  input  1  sole clock SHALL be used; all state updates on its rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset SHALL clear all state immediately on assertion.
- REQ-004: gray_in  input  4  asynchronous 4-bit Gray code from switches/encoder.
- REQ-005: binary_code  output  4  committed binary value, registered, SHALL feed the 7-segment display stage directly.
- REQ-006: update  output  1  SHALL be a one-cycle pulse coincident with each change of binary_code.
- REQ-007: seq_err  output  1  SHALL be a one-cycle pulse when a committed Gray word differs from the previously committed word in more than one bit.
- REQ-008: out_of_range  output  1  SHALL be a one-cycle pulse for a rejected non-BCD value (see Configuration); always present.

Function
- REQ-009: gray_in SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
- REQ-010: A candidate register cand SHALL load s2 each cycle s2 != cand, clearing the stability counter cnt to 0.
- REQ-011: While s2 == cand, cnt SHALL increment by 1 per cycle, saturating at STABLE_CYCLES.
- REQ-012: FSM SHALL have two states: STABLE (cnt == STABLE_CYCLES) and SETTLING (cnt < STABLE_CYCLES); any s2 != cand SHALL force SETTLING.
- REQ-013: Commit SHALL occur on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, only if cand != committed Gray register gcom.
- REQ-014: On commit, gcom <= cand, binary_code <= gray2bin(cand) (b3=g3, bi=b(i+1) XOR gi), update <= 1 on the same edge.
- REQ-015: Latency: a new value held steady SHALL appear on binary_code at the (STABLE_CYCLES+3)th rising edge that samples it (7th for default).
- REQ-016: Any input change shorter than STABLE_CYCLES+1 synchronized cycles SHALL produce no commit, no pulse.
- REQ-017: seq_err SHALL assert with update when popcount(cand XOR gcom_old) > 1; binary_code still updates.
- REQ-018: Re-settling on the already committed value SHALL produce no pulse; update, seq_err, out_of_range SHALL otherwise be 0.

Reset
- REQ-019: On rst_n low: s1, s2, cand, gcom, binary_code = 0; cnt = 0; state SETTLING; update, seq_err, out_of_range = 0.
- REQ-020: Reset mid-settle SHALL discard the pending candidate; no pulse on release unless the input re-qualifies per REQ-013.

Configuration
- REQ-021: Macro BCD_CLAMP_EN defined: a commit whose gray2bin(cand) > 9 SHALL update gcom, hold binary_code, suppress update, pulse out_of_range (seq_err still evaluated).
- REQ-022: BCD_CLAMP_EN undefined: values 10..15 SHALL commit normally; out_of_range SHALL be tied 0.

Verification (STABLE_CYCLES=4)
- REQ-023: Reset release with gray_in=0001 held -> binary_code 0000 through edge 6, 0001 at edge 7, update single pulse, seq_err 0.
- REQ-024: Walk gray 0001->0011->0010->0110, each held 10 cycles -> binary 0010, 0011, 0100, four update pulses, seq_err never 1.
- REQ-025: From committed 0110, drive 0111 for 2 cycles then back to 0110 -> no update, binary_code stays 0100.
- REQ-026: From committed 0000 jump to 0101 -> binary_code 0110 with update and seq_err pulsing together.
- REQ-027: Commit 1101 (binary 1001), then 1111 -> with BCD_CLAMP_EN: binary_code stays 1001, out_of_range pulse, no update; without: binary_code 1010 with update.
- REQ-028: Assert rst_n low 2 cycles into settling of 0011 -> all outputs 0 immediately, no update after release until REQ-015 latency elapses again.

Source files
------------

// File: rtl/gray_input_conditioner.sv
// Gray-code switch/encoder input conditioner: synchronize, debounce, commit, convert to binary.
// Optional BCD_CLAMP_EN: commits decoding above 9 update gcom but hold binary_code and pulse out_of_range.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SETTLING | candidate changed recently, cnt < STABLE_CYCLES
// STABLE   | candidate held for STABLE_CYCLES cycles, cnt saturated
module gray_input_conditioner #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gray_in,
    output logic [3:0] binary_code,
    output logic       update,
    output logic       seq_err,
    output logic       out_of_range
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        SETTLING = 1'b0,
        STABLE   = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;
    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gcom_q, gcom_d;
    logic [3:0] bin_q, bin_d;
    logic       upd_q, upd_d;
    logic       seq_q, seq_d;
    logic       oor_q, oor_d;
    logic       commit;
    logic [3:0] bin_new;
    logic [3:0] diff;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign bin_new = gray2bin(cand_q);
    assign diff    = cand_q ^ gcom_q;

    always_comb begin
        s1_d    = gray_in;
        s2_d    = s1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            SETTLING: begin
                if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_PRE) begin
                        state_d = STABLE;
                        commit  = (cand_q != gcom_q);
                    end
                end
            end
            STABLE: begin
                if (s2_q != cand_q) begin
                    cand_d  = s2_q;
                    cnt_d   = 8'd0;
                    state_d = SETTLING;
                end else begin
                    cnt_d = CNT_MAX;
                end
            end
            default: begin
                state_d = SETTLING;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        gcom_d = gcom_q;
        bin_d  = bin_q;
        upd_d  = 1'b0;
        seq_d  = 1'b0;
        oor_d  = 1'b0;
        if (commit) begin
            gcom_d = cand_q;
            // more than one bit set <=> clearing the lowest set bit leaves something
            seq_d  = ((diff & (diff - 4'd1)) != 4'd0);
`ifdef BCD_CLAMP_EN
            if (bin_new > 4'd9) begin
                oor_d = 1'b1;
            end else begin
                bin_d = bin_new;
                upd_d = (bin_new != bin_q);
            end
`else
            bin_d = bin_new;
            upd_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLING;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            cand_q  <= 4'd0;
            cnt_q   <= 8'd0;
            gcom_q  <= 4'd0;
            bin_q   <= 4'd0;
            upd_q   <= 1'b0;
            seq_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            gcom_q  <= gcom_d;
            bin_q   <= bin_d;
            upd_q   <= upd_d;
            seq_q   <= seq_d;
            oor_q   <= oor_d;
        end
    end

    assign binary_code  = bin_q;
    assign update       = upd_q;
    assign seq_err      = seq_q;
    assign out_of_range = oor_q;

endmodule

// File: tb/tb_gray_input_conditioner.sv
// Bench for gray_input_conditioner: directed table, reset sequences, random holds vs a history-based model.
module tb_gray_input_conditioner;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_in = 4'd0;
    logic [3:0] binary_code;
    logic       update, seq_err, out_of_range;

    gray_input_conditioner #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in),
        .binary_code(binary_code), .update(update),
        .seq_err(seq_err), .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int upd_cnt, seq_cnt, oor_cnt;

    // reference model: two-sample input delay plus history of samples seen by the debouncer
    logic [3:0] m_s1, m_s2, m_gcom, m_bin;
    int         hist[$];
    bit         m_upd, m_seq, m_oor;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_gcom = 0; m_bin = 0;
        m_upd = 0; m_seq = 0; m_oor = 0;
        hist.delete();
        hist.push_back(0);
    endfunction

    function automatic void model_edge(input logic [3:0] g);
        int seen, run, ones, bin, d;
        seen = int'(m_s2);
        m_s2 = m_s1;
        m_s1 = g;
        hist.push_back(seen);
        if (hist.size() > S + 3) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != seen) break;
            run++;
        end
        m_upd = 0; m_seq = 0; m_oor = 0;
        if (run == S + 1 && seen != int'(m_gcom)) begin
            d = seen ^ int'(m_gcom);
            ones = 0;
            for (int k = 0; k < 4; k++) ones += (d >> k) & 1;
            m_seq = (ones > 1);
            bin = seen ^ (seen >> 1) ^ (seen >> 2) ^ (seen >> 3);
            m_gcom = 4'(seen);
`ifdef BCD_CLAMP_EN
            if (bin > 9) m_oor = 1;
            else begin
                m_upd = (bin != int'(m_bin));
                m_bin = 4'(bin);
            end
`else
            m_upd = 1;
            m_bin = 4'(bin);
`endif
        end
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("binary_code", int'(binary_code), int'(m_bin));
        check("update", int'(update), int'(m_upd));
        check("seq_err", int'(seq_err), int'(m_seq));
        check("out_of_range", int'(out_of_range), int'(m_oor));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(gray_in);
        #1;
        check_model();
        upd_cnt += int'(update);
        seq_cnt += int'(seq_err);
        oor_cnt += int'(out_of_range);
    endtask

    typedef struct {
        logic [3:0] g;
        int         hold;
        logic [3:0] bin;
        int         upd;
        int         seq;
        int         oor;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{4'b0011, 10, 4'b0010, 1, 0, 0};
        vt[1] = '{4'b0010, 10, 4'b0011, 1, 0, 0};
        vt[2] = '{4'b0110, 10, 4'b0100, 1, 0, 0};
        vt[3] = '{4'b0111,  2, 4'b0100, 0, 0, 0};
        vt[4] = '{4'b0110, 10, 4'b0100, 0, 0, 0};
        vt[5] = '{4'b0000, 10, 4'b0000, 1, 1, 0};
        vt[6] = '{4'b0101, 10, 4'b0110, 1, 1, 0};
        vt[7] = '{4'b1101, 10, 4'b1001, 1, 0, 0};
`ifdef BCD_CLAMP_EN
        vt[8] = '{4'b1111, 10, 4'b1001, 0, 0, 1};
`else
        vt[8] = '{4'b1111, 10, 4'b1010, 1, 0, 0};
`endif

        // reset state and first-commit latency with 0001 held through release
        model_reset();
        gray_in = 4'b0001;
        #12;
        check("reset binary_code", int'(binary_code), 0);
        check("reset pulses", int'({update, seq_err, out_of_range}), 0);
        rst_n = 1'b1;
        upd_cnt = 0; seq_cnt = 0; oor_cnt = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("latency edge%0d binary", e), int'(binary_code), (e < 7) ? 0 : 1);
            check($sformatf("latency edge%0d update", e), int'(update), (e == 7) ? 1 : 0);
        end
        for (int e = 0; e < 3; e++) tick();
        check("first commit update count", upd_cnt, 1);
        check("first commit seq_err count", seq_cnt, 0);

        // directed walk, glitch rejection, multi-bit jump, range boundary
        for (int v = 0; v < 9; v++) begin
            gray_in = vt[v].g;
            upd_cnt = 0; seq_cnt = 0; oor_cnt = 0;
            for (int c = 0; c < vt[v].hold; c++) tick();
            check($sformatf("vec%0d binary", v), int'(binary_code), int'(vt[v].bin));
            check($sformatf("vec%0d update count", v), upd_cnt, vt[v].upd);
            check($sformatf("vec%0d seq_err count", v), seq_cnt, vt[v].seq);
            check($sformatf("vec%0d out_of_range count", v), oor_cnt, vt[v].oor);
        end

        // reset asserted two cycles into settling of 0011
        gray_in = 4'b0011;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("async reset binary", int'(binary_code), 0);
        check("async reset pulses", int'({update, seq_err, out_of_range}), 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        upd_cnt = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("post-reset edge%0d update", e), int'(update), (e == 7) ? 1 : 0);
        end
        check("post-reset binary", int'(binary_code), 2);
        check("post-reset update count", upd_cnt, 1);

        // random holds, many shorter than the qualification window
        for (int seg = 0; seg < 200; seg++) begin
            gray_in = 4'($urandom_range(0, 15));
            for (int c = 0, n = int'($urandom_range(1, 9)); c < n; c++) tick();
        end
        for (int c = 0; c < 10; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
